// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
// Central stall/flush controller for a five-stage pipeline. It arbitrates
// between SRAM wait stalls in MEM, taken branches resolved in EXE and data
// hazards detected in ID, and runs a small FSM that bounds each SRAM access
// to MEM_TIMEOUT stalled cycles before aborting it.
//
// Optional feature macro: STALL_COUNTERS_EN
//   defined   -> saturating 16-bit hazard/mem stall performance counters
//   undefined -> counter outputs tied to zero, no counter flops
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_detected,
  input  logic        branch_taken,
  input  logic        MEM_R_EN_MEM,
  input  logic        MEM_W_EN_MEM,
  input  logic        sram_ready,
  output logic        freeze_IF,
  output logic        freeze_ID,
  output logic        freeze_EXE,
  output logic        freeze_MEM,
  output logic        flush_IF_ID,
  output logic        bubble_ID_EXE,
  output logic        mem_wait,
  output logic        timeout_err,
  output logic [15:0] hazard_stall_cnt,
  output logic [15:0] mem_stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } state_t;

  // The IDLE cycle that first sees the stalled request is itself a stalled
  // cycle, so WAIT only has to cover MEM_TIMEOUT-1 further cycles. wait_cnt
  // counts completed WAIT cycles, hence the abort point is MEM_TIMEOUT-2.
  localparam logic [7:0] ABORT_AT = 8'(MEM_TIMEOUT - 2);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       mem_req;
  logic       mem_stall;
  logic       hazard_stall;

  assign mem_req      = MEM_R_EN_MEM | MEM_W_EN_MEM;
  assign mem_stall    = ~rst & mem_req & ~sram_ready & (state != ABORT);
  assign hazard_stall = hazard_detected & ~branch_taken;

  // Stall/flush decode: memory stall dominates everything, a taken branch
  // squashes the ID instruction so a concurrent hazard needs no stall.
  always_comb begin
    freeze_EXE    = mem_stall;
    freeze_MEM    = mem_stall;
    freeze_IF     = ~rst & (mem_stall | hazard_stall);
    freeze_ID     = ~rst & (mem_stall | hazard_stall);
    flush_IF_ID   = ~rst & branch_taken & ~mem_stall;
    bubble_ID_EXE = ~rst & ~mem_stall & (branch_taken | hazard_detected);
  end

  // SRAM access FSM with registered mem_wait and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      mem_wait    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wait_cnt <= 8'd0;
          if (mem_stall) begin
            state    <= WAIT;
            mem_wait <= 1'b1;
          end
        end
        WAIT: begin
          if (sram_ready) begin
            state    <= IDLE;
            mem_wait <= 1'b0;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == ABORT_AT) begin
            state    <= ABORT;
            mem_wait <= 1'b0;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ABORT: begin
          state       <= IDLE;
          mem_wait    <= 1'b0;
          wait_cnt    <= 8'd0;
          timeout_err <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          mem_wait <= 1'b0;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

`ifdef STALL_COUNTERS_EN
  logic [15:0] hazard_cnt_q;
  logic [15:0] mem_cnt_q;

  // Saturating stall performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hazard_cnt_q <= 16'd0;
      mem_cnt_q    <= 16'd0;
    end else begin
      if (hazard_stall && !mem_stall && hazard_cnt_q != 16'hFFFF)
        hazard_cnt_q <= hazard_cnt_q + 16'd1;
      if (mem_stall && mem_cnt_q != 16'hFFFF)
        mem_cnt_q <= mem_cnt_q + 16'd1;
    end
  end

  assign hazard_stall_cnt = hazard_cnt_q;
  assign mem_stall_cnt    = mem_cnt_q;
`else
  assign hazard_stall_cnt = 16'd0;
  assign mem_stall_cnt    = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller
// Directed bench for pipeline_stall_controller (MEM_TIMEOUT=4): a table of
// combinational vectors followed by hand-written multi-cycle sequences.
// Counter expectations follow STALL_COUNTERS_EN when the macro is defined.
module tb_pipeline_stall_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard_detected;
  logic        branch_taken;
  logic        MEM_R_EN_MEM;
  logic        MEM_W_EN_MEM;
  logic        sram_ready;
  logic        freeze_IF;
  logic        freeze_ID;
  logic        freeze_EXE;
  logic        freeze_MEM;
  logic        flush_IF_ID;
  logic        bubble_ID_EXE;
  logic        mem_wait;
  logic        timeout_err;
  logic [15:0] hazard_stall_cnt;
  logic [15:0] mem_stall_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_h    = 0;
  int exp_m    = 0;

`ifdef STALL_COUNTERS_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  // Inputs {hazard, branch, rd, wr, ready}, expected
  // {freeze_IF, freeze_ID, freeze_EXE, freeze_MEM, flush, bubble}.
  typedef struct packed {
    logic       hazard;
    logic       branch;
    logic       rd;
    logic       wr;
    logic       ready;
    logic [5:0] expect_out;
  } vec_t;

  vec_t vecs [12];

  pipeline_stall_controller #(.MEM_TIMEOUT(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .hazard_detected  (hazard_detected),
    .branch_taken     (branch_taken),
    .MEM_R_EN_MEM     (MEM_R_EN_MEM),
    .MEM_W_EN_MEM     (MEM_W_EN_MEM),
    .sram_ready       (sram_ready),
    .freeze_IF        (freeze_IF),
    .freeze_ID        (freeze_ID),
    .freeze_EXE       (freeze_EXE),
    .freeze_MEM       (freeze_MEM),
    .flush_IF_ID      (flush_IF_ID),
    .bubble_ID_EXE    (bubble_ID_EXE),
    .mem_wait         (mem_wait),
    .timeout_err      (timeout_err),
    .hazard_stall_cnt (hazard_stall_cnt),
    .mem_stall_cnt    (mem_stall_cnt)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Hard stop in case the sequence stalls unexpectedly.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic h, input logic b, input logic r,
                               input logic w, input logic rdy);
    hazard_detected = h;
    branch_taken    = b;
    MEM_R_EN_MEM    = r;
    MEM_W_EN_MEM    = w;
    sram_ready      = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  function automatic logic [5:0] combOut();
    return {freeze_IF, freeze_ID, freeze_EXE, freeze_MEM, flush_IF_ID, bubble_ID_EXE};
  endfunction

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_hcnt"}, hazard_stall_cnt, CNT_ON ? 16'(exp_h) : 16'd0);
    checkOutput({tag, "_mcnt"}, mem_stall_cnt,    CNT_ON ? 16'(exp_m) : 16'd0);
  endtask

  initial begin
    vecs[0]  = 11'b00000_000000;
    vecs[1]  = 11'b10000_110001;
    vecs[2]  = 11'b01000_000011;
    vecs[3]  = 11'b11000_000011;
    vecs[4]  = 11'b00101_000000;
    vecs[5]  = 11'b00011_000000;
    vecs[6]  = 11'b00100_111100;
    vecs[7]  = 11'b00010_111100;
    vecs[8]  = 11'b11100_111100;
    vecs[9]  = 11'b10010_111100;
    vecs[10] = 11'b01111_000011;
    vecs[11] = 11'b10101_110001;

    // Reset held with active-looking inputs: everything must read zero.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("rst_comb", {10'd0, combOut()}, 16'd0);
    checkOutput("rst_mem_wait", {15'd0, mem_wait}, 16'd0);
    checkOutput("rst_timeout", {15'd0, timeout_err}, 16'd0);
    checkCounters("rst");
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Table: each vector for one cycle, then a recovery cycle that lets
    // any entered WAIT complete with sram_ready high.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].hazard, vecs[i].branch, vecs[i].rd, vecs[i].wr, vecs[i].ready);
      #1;
      checkOutput($sformatf("vec%0d_comb", i), {10'd0, combOut()}, {10'd0, vecs[i].expect_out});
      checkOutput($sformatf("vec%0d_mem_wait", i), {15'd0, mem_wait}, 16'd0);
      if (vecs[i].hazard && !vecs[i].branch && !vecs[i].expect_out[2]) exp_h++;
      if (vecs[i].expect_out[2]) exp_m++;
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkCounters("table");

    // Read with three wait cycles.
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, (c == 4));
      #1;
      checkOutput($sformatf("wait3_c%0d_freeze_IF", c), {15'd0, freeze_IF}, {15'd0, (c < 4)});
      checkOutput($sformatf("wait3_c%0d_freeze_MEM", c), {15'd0, freeze_MEM}, {15'd0, (c < 4)});
      checkOutput($sformatf("wait3_c%0d_mem_wait", c), {15'd0, mem_wait}, {15'd0, (c > 1)});
    end
    exp_m += 3;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("wait3_done_mem_wait", {15'd0, mem_wait}, 16'd0);
    checkCounters("wait3");

    // Timeout: IDLE + 3 WAIT stalled cycles, then one ABORT cycle.
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("tmo_c%0d_freeze_IF", c), {15'd0, freeze_IF}, {15'd0, (c < 5)});
      checkOutput($sformatf("tmo_c%0d_freeze_EXE", c), {15'd0, freeze_EXE}, {15'd0, (c < 5)});
      checkOutput($sformatf("tmo_c%0d_mem_wait", c), {15'd0, mem_wait},
                  {15'd0, (c >= 2 && c <= 4)});
      if (c < 5) checkOutput($sformatf("tmo_c%0d_err", c), {15'd0, timeout_err}, 16'd0);
    end
    exp_m += 4;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("tmo_err_set", {15'd0, timeout_err}, 16'd1);
    checkOutput("tmo_after_mem_wait", {15'd0, mem_wait}, 16'd0);
    checkCounters("tmo");
    @(negedge clk);
    #1;
    checkOutput("tmo_err_sticky", {15'd0, timeout_err}, 16'd1);

    // Branch arriving during a 2-cycle write wait is flushed on release.
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, (c == 3));
      #1;
      checkOutput($sformatf("brw_c%0d_flush", c), {15'd0, flush_IF_ID}, {15'd0, (c == 3)});
      checkOutput($sformatf("brw_c%0d_bubble", c), {15'd0, bubble_ID_EXE}, {15'd0, (c == 3)});
      checkOutput($sformatf("brw_c%0d_freeze_EXE", c), {15'd0, freeze_EXE}, {15'd0, (c < 3)});
    end
    exp_m += 2;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkCounters("brw");

    // Asynchronous reset mid-WAIT, between clock edges.
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("arst_pre_mem_wait", {15'd0, mem_wait}, 16'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("arst_comb", {10'd0, combOut()}, 16'd0);
    checkOutput("arst_mem_wait", {15'd0, mem_wait}, 16'd0);
    checkOutput("arst_timeout", {15'd0, timeout_err}, 16'd0);
    exp_h = 0;
    exp_m = 0;
    checkCounters("arst");
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("arst_post_mem_wait", {15'd0, mem_wait}, 16'd0);
    checkOutput("arst_post_timeout", {15'd0, timeout_err}, 16'd0);
    checkCounters("arst_post");

    // After reset the FSM is back in IDLE: a zero-wait read needs no stall.
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    checkOutput("arst_zero_wait_comb", {10'd0, combOut()}, 16'd0);
    @(negedge clk);
    #1;
    checkOutput("arst_zero_wait_mem_wait", {15'd0, mem_wait}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
